// File: rtl/register_file.sv
// 32-entry integer register file: x0 reads zero, sp/gp take memory-map reset values.
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_RESET  = 32'h7FFF_EFFC,
    parameter logic [DATA_WIDTH-1:0] GP_RESET  = 32'h1000_8000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Reg_Write_i,
    input  logic [ADDR_WIDTH-1:0] Write_Register_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
    output logic [DATA_WIDTH-1:0] Read_Data_1_o,
    output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];
    logic                  wr_en;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int unsigned idx);
        unique case (idx)
            2:       reset_value = SP_RESET;
            3:       reset_value = GP_RESET;
            default: reset_value = '0;
        endcase
    endfunction

    // x0 has no storage, so a write to index 0 simply never matches a flop
    assign wr_en = Reg_Write_i && (Write_Register_i != '0);

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (wr_en && (Write_Register_i == ADDR_WIDTH'(i))) begin
                regs_d[i] = Write_Data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        Read_Data_1_o = '0;
        Read_Data_2_o = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (Read_Register_1_i == ADDR_WIDTH'(i)) begin
                Read_Data_1_o = regs_q[i];
            end
            if (Read_Register_2_i == ADDR_WIDTH'(i)) begin
                Read_Data_2_o = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed in reset so outputs show reset contents
        if (reset && wr_en && (Read_Register_1_i == Write_Register_i)) begin
            Read_Data_1_o = Write_Data_i;
        end
        if (reset && wr_en && (Read_Register_2_i == Write_Register_i)) begin
            Read_Data_2_o = Write_Data_i;
        end
`else
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected reads,
// a negedge monitor pops and compares them against the read ports.
module tb_register_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    typedef struct {
        bit          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    register_file dut (
        .clk              (clk),
        .reset            (reset),
        .Reg_Write_i      (we),
        .Write_Register_i (wa),
        .Write_Data_i     (wd),
        .Read_Register_1_i(ra1),
        .Read_Register_2_i(ra2),
        .Read_Data_1_o    (rd1),
        .Read_Data_2_o    (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            act = e.port ? rd2 : rd1;
            n_total++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: port%0d got %h expected %h",
                         e.name, e.port ? 2 : 1, act, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit port, input logic [31:0] exp, input string nm);
        chk_t e;
        e.port = port;
        e.exp  = exp;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rst_exp(input int idx);
        if (idx == 2) return SP;
        if (idx == 3) return GP;
        return 32'h0;
    endfunction

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra1   = 5'd2;
        ra2   = 5'd3;
        #1;
        chk(0, SP, "in_reset_sp");
        chk(1, GP, "in_reset_gp");
        cyc();
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cyc();
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            chk(0, rst_exp(i), $sformatf("rst_idx%0d_p1", i));
            chk(1, rst_exp(31 - i), $sformatf("rst_idx%0d_p2", 31 - i));
        end

        cyc();
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        ra1 = 5'd4; ra2 = 5'd6;
        chk(0, 32'h0, "x4_during_w5");
        chk(1, 32'h0, "x6_during_w5");
        cyc();
        we = 1'b0;
        ra1 = 5'd5; ra2 = 5'd5;
        chk(0, 32'hDEAD_BEEF, "x5_p1");
        chk(1, 32'hDEAD_BEEF, "x5_p2");
        cyc();
        ra1 = 5'd4; ra2 = 5'd6;
        chk(0, 32'h0, "x4_unchanged");
        chk(1, 32'h0, "x6_unchanged");

        cyc();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        ra1 = 5'd0; ra2 = 5'd0;
        chk(0, 32'h0, "x0_during_write_p1");
        chk(1, 32'h0, "x0_during_write_p2");
        cyc();
        we = 1'b0;
        chk(0, 32'h0, "x0_after_write_p1");
        chk(1, 32'h0, "x0_after_write_p2");

        cyc();
        we = 1'b0; wa = 5'd7; wd = 32'h0000_1234;
        ra1 = 5'd7;
        chk(0, 32'h0, "x7_we0_before");
        cyc();
        chk(0, 32'h0, "x7_we0_after");

        cyc();
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5_A5A5;
        ra1 = 5'd8; ra2 = 5'd9;
        chk(0, 32'h0, "x8_neighbour");
`ifdef REGFILE_BYPASS_EN
        chk(1, 32'hA5A5_A5A5, "x9_same_cycle");
`else
        chk(1, 32'h0, "x9_same_cycle");
`endif
        cyc();
        we = 1'b0;
        chk(1, 32'hA5A5_A5A5, "x9_after_edge");

        cyc();
        we = 1'b1; wa = 5'd31; wd = 32'h0000_0011;
        cyc();
        wa = 5'd1; wd = 32'h0000_0022;
        cyc();
        we = 1'b0;
        ra1 = 5'd31; ra2 = 5'd1;
        chk(0, 32'h0000_0011, "x31_boundary");
        chk(1, 32'h0000_0022, "x1_boundary");

        cyc();
        we = 1'b1; wa = 5'd2; wd = 32'h0000_0100;
        cyc();
        we = 1'b0;
        ra1 = 5'd2; ra2 = 5'd5;
        chk(0, 32'h0000_0100, "x2_written");
        @(negedge clk);
        #1;
        reset = 1'b0;
        we = 1'b1; wa = 5'd2; wd = 32'h0000_0BAD;
        chk(0, SP, "x2_async_reset");
        chk(1, 32'h0, "x5_async_reset");
        cyc();
        chk(0, SP, "x2_write_in_reset");
        cyc();
        we = 1'b0;
        reset = 1'b1;
        ra2 = 5'd3;
        chk(0, SP, "x2_after_release");
        chk(1, GP, "x3_after_release");

        cyc();
        cyc();
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
